bram_uart_streamer: RTL and testbench

- Drains the file bytes that the SD file-reader path has stored in the 1K x 8 BRAM and transmits them to the host PC over UART as 8N1 frames.
- It owns the BRAM read port, stepping addresses 0..N-1 in order.
- It drives the board's uart_tx pin. It starts on a single-cycle start pulse and reports busy and done.

---
 rtl/bram_uart_streamer_pkg.sv | 22 ++
 rtl/bram_uart_streamer_uart_tx.sv | 71 +++++++
 rtl/bram_uart_streamer.sv | 111 +++++++++++
 tb/tb_bram_uart_streamer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_uart_streamer_pkg.sv
// Shared types for the BRAM-to-UART streamer.
// Holds the streamer FSM states and the baud divisor helper.
package bram_uart_streamer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_e;

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int unsigned uart_div(
    input int unsigned clk_freq,
    input int unsigned baud
  );
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/bram_uart_streamer_uart_tx.sv
// uart_tx_byte: 8N1 serialiser, one byte per valid/ready handshake.
// Ports: clk, rstn, tx_valid, tx_data[7:0], tx_ready, tx (idle high).
module uart_tx_byte
  import bram_uart_streamer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx
);

  localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [7:0]    sh_q;
  logic          busy_q;
  logic          tx_q;
  logic          bit_end;
  logic          last;
  logic          accept;

  assign bit_end  = busy_q && (cnt_q == CW'(DIV - 1));
  // Ready in the final stop-bit cycle so the next byte can
  // be handed over without an extra idle cycle.
  assign last     = bit_end && (bit_q == 4'd9);
  assign tx_ready = !busy_q || last;
  assign accept   = tx_valid && tx_ready;
  assign tx       = tx_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
    end else if (accept) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= tx_data;
      busy_q <= 1'b1;
      tx_q   <= 1'b0;
    end else if (busy_q) begin
      if (bit_end) begin
        cnt_q <= '0;
        if (bit_q == 4'd9) begin
          busy_q <= 1'b0;
          bit_q  <= '0;
        end else begin
          bit_q <= bit_q + 4'd1;
          if (bit_q == 4'd8) begin
            tx_q <= 1'b1;
          end else begin
            tx_q <= sh_q[0];
            sh_q <= sh_q >> 1;
          end
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bram_uart_streamer.sv
// Streams BRAM bytes 0..N-1 out of the UART as 8N1 frames.
// Ports: clk, rstn, start, byte_count, pause, bram_addr/bram_data,
// uart_tx, busy, done, tx_count.
module bram_uart_streamer
  import bram_uart_streamer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W:0]   byte_count,
  input  logic              pause,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   tx_count
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   txc_q, txc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   idx_nxt;
  logic              tx_valid;
  logic              tx_ready;

  // idx is one bit wider than the address so a full-depth
  // transfer terminates instead of wrapping.
  assign idx_nxt = idx_q + (ADDR_W + 1)'(1);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    txc_d    = txc_q;
    addr_d   = addr_q;
    tx_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = byte_count;
          idx_d   = '0;
          txc_d   = '0;
          addr_d  = '0;
          state_d = (byte_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!pause) begin
          addr_d  = idx_q[ADDR_W-1:0];
          state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = S_LOAD;
      S_LOAD: begin
        tx_valid = 1'b1;
        if (tx_ready) state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          txc_d   = txc_q + (ADDR_W + 1)'(1);
          idx_d   = idx_nxt;
          state_d = (idx_nxt == len_q) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      txc_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      txc_q   <= txc_d;
      addr_q  <= addr_d;
    end
  end

  assign busy = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                (state_q == S_LOAD)  || (state_q == S_SEND);
  assign done      = (state_q == S_DONE);
  assign bram_addr = addr_q;
  assign tx_count  = txc_q;

  uart_tx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tx (
    .clk      (clk),
    .rstn     (rstn),
    .tx_valid (tx_valid),
    .tx_data  (bram_data),
    .tx_ready (tx_ready),
    .tx       (uart_tx)
  );

endmodule

// File: tb/tb_bram_uart_streamer.sv
// Directed bench for bram_uart_streamer with a small baud divisor.
// A BRAM model feeds the DUT; frames on uart_tx are decoded in line.
module tb_bram_uart_streamer;

  // (1150 + 125) / 250 = 5; plain truncation would give 4.
  localparam int unsigned CLK_FREQ = 1150;
  localparam int unsigned BAUD     = 250;
  localparam int          DIV      = 5;
  localparam int          AW       = 10;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AW:0]   byte_count;
  logic          pause;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_data;
  logic          uart_tx;
  logic          busy;
  logic          done;
  logic [AW:0]   tx_count;

  logic [7:0] mem [0:1023];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  bram_uart_streamer #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .ADDR_W   (AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .byte_count (byte_count),
    .pause      (pause),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .done       (done),
    .tx_count   (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bram_data <= mem[bram_addr];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit; idle = high cycles seen before it.
  task automatic wait_low(input int limit, output int idle,
                          output bit ok);
    idle = 0;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      idle++;
    end
  endtask

  // Called at the first start-bit sample; returns at the
  // last stop-bit cycle. Every bit must hold for DIV cycles.
  task automatic rx_frame(output logic [7:0] b, output bit tim_ok);
    logic [9:0] bits;
    bits = '0;
    tim_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < DIV; j++) begin
        if (k != 0 || j != 0) begin
          @(negedge clk);
          start = 1'b0;
        end
        if (j == 0) bits[k] = uart_tx;
        else if (uart_tx !== bits[k]) tim_ok = 1'b0;
      end
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) tim_ok = 1'b0;
    b = bits[8:1];
  endtask

  task automatic pulse_start(input logic [AW:0] n);
    @(negedge clk);
    byte_count = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_text();
    mem[0] = 8'h48;
    mem[1] = 8'h69;
    mem[2] = 8'h0A;
    mem[3] = 8'hC3;
  endtask

  logic [7:0] b;
  bit ok, tok, flag;
  int idle, bad, dc0;
  logic [7:0] exp3 [0:2];

  initial begin
    exp3[0] = 8'h48;
    exp3[1] = 8'h69;
    exp3[2] = 8'h0A;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    load_text();
    rstn = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    byte_count = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_count", tx_count, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Three-byte text; stray start and byte_count changes mid-run.
    dc0 = done_cnt;
    pulse_start(11'd3);
    check("t1_busy", busy, 1);
    wait_low(20, idle, ok);
    check("t1_first_ok", ok, 1);
    check("t1_first_gap", idle, 2);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        byte_count = 11'd7;
        start = 1'b1;
      end
      rx_frame(b, tok);
      check("t1_byte", b, exp3[i]);
      check("t1_timing", tok, 1);
      if (i < 2) begin
        wait_low(20, idle, ok);
        check("t1_gap", idle, 3);
        check("t1_cnt", tx_count, i + 1);
      end
    end
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_busy_done", busy, 0);
    check("t1_count", tx_count, 3);
    check("t1_addr_hold", bram_addr, 2);
    @(negedge clk);
    check("t1_done_fall", done, 0);
    wait_low(60, idle, ok);
    check("t1_no_extra", ok, 0);
    check("t1_done_pulses", done_cnt - dc0, 1);

    // Zero-length transfer.
    dc0 = done_cnt;
    @(negedge clk);
    byte_count = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    check("t2_tx", uart_tx, 1);
    check("t2_count", tx_count, 0);
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || done !== 1'b0) flag = 1'b1;
    end
    check("t2_quiet", flag, 0);
    check("t2_pulses", done_cnt - dc0, 1);

    // Pause raised during byte 1 of 4.
    pulse_start(11'd4);
    wait_low(20, idle, ok);
    rx_frame(b, tok);
    check("t3_b0", b, 8'h48);
    wait_low(20, idle, ok);
    pause = 1'b1;
    rx_frame(b, tok);
    check("t3_b1", b, 8'h69);
    check("t3_b1_timing", tok, 1);
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b1) flag = 1'b1;
    end
    check("t3_held", flag, 0);
    check("t3_held_cnt", tx_count, 2);
    pause = 1'b0;
    wait_low(20, idle, ok);
    check("t3_resume_gap", idle, 2);
    rx_frame(b, tok);
    check("t3_b2", b, 8'h0A);
    wait_low(20, idle, ok);
    rx_frame(b, tok);
    check("t3_b3", b, 8'hC3);
    @(negedge clk);
    check("t3_done", done, 1);
    check("t3_count", tx_count, 4);

    // Full depth: 1024 bytes, data = address.
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    pulse_start(11'd1024);
    bad = 0;
    wait_low(20, idle, ok);
    for (int i = 0; i < 1024; i++) begin
      if (!ok) begin
        bad++;
        break;
      end
      rx_frame(b, tok);
      if (b !== i[7:0] || !tok) bad++;
      if (i < 1023) begin
        wait_low(20, idle, ok);
        if (idle != 3) bad++;
      end
    end
    check("t4_last_byte", b, 8'hFF);
    check("t4_bad_frames", bad, 0);
    @(negedge clk);
    check("t4_done", done, 1);
    check("t4_count", tx_count, 1024);
    check("t4_addr_hold", bram_addr, 1023);
    wait_low(60, idle, ok);
    check("t4_no_wrap", ok, 0);

    // Reset in the middle of data bit 2 of byte 2.
    load_text();
    pulse_start(11'd4);
    wait_low(20, idle, ok);
    rx_frame(b, tok);
    wait_low(20, idle, ok);
    rx_frame(b, tok);
    wait_low(20, idle, ok);
    repeat (17) @(negedge clk);
    check("t5_pre_line", uart_tx, 0);
    dc0 = done_cnt;
    #2 rstn = 1'b0;
    #1;
    check("t5_async_tx", uart_tx, 1);
    check("t5_async_busy", busy, 0);
    check("t5_async_done", done, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check("t5_addr", bram_addr, 0);
    check("t5_count", tx_count, 0);
    repeat (20) @(negedge clk);
    check("t5_no_done", done_cnt - dc0, 0);
    pulse_start(11'd2);
    wait_low(20, idle, ok);
    rx_frame(b, tok);
    check("t5_b0", b, 8'h48);
    wait_low(20, idle, ok);
    rx_frame(b, tok);
    check("t5_b1", b, 8'h69);
    @(negedge clk);
    check("t5_done", done, 1);
    check("t5_tx_count", tx_count, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
